// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for pipelined_block_adder.
//   DEF_DATA_WIDTH / DEF_BLOCK_WIDTH : default geometry (32 / 8).
//   num_stages()                     : pipeline depth = data width / block width.
//   op_e                             : ADD (0) / SUB (1), matches subtract_i.
//   stage_t                          : one pipeline register: valid, result
//                                      slices done so far, carry into the next
//                                      slice, signed overflow (meaningful in the
//                                      last stage), and the A/B' operands whose
//                                      upper slices are still to be summed.
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_BLOCK_WIDTH = 8;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_e;

   function automatic int num_stages(input int data_width, input int block_width);
      return data_width / block_width;
   endfunction

   // Field widths follow the default data width; the adder's DATA_WIDTH
   // parameter must equal DEF_DATA_WIDTH for this record to fit.
   typedef struct packed {
      logic                      valid;
      logic [DEF_DATA_WIDTH-1:0] sum;
      logic                      carry;
      logic                      overflow;
      logic [DEF_DATA_WIDTH-1:0] a;
      logic [DEF_DATA_WIDTH-1:0] b;
   } stage_t;

endpackage

// File: rtl/pipelined_block_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_block_adder_if
// Operand/result bus of the pipelined adder with valid/ready on both sides.
//   master : operand source / result consumer (drives valid_i, operands,
//            carry_i, subtract_i, ready_i).
//   slave  : the adder (drives ready_o, valid_o, result_o, carry_o,
//            overflow_o).
// -----------------------------------------------------------------------------
interface pipelined_block_adder_if
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic                  valid_i;
   logic                  ready_o;
   logic [DATA_WIDTH-1:0] operand_A_i;
   logic [DATA_WIDTH-1:0] operand_B_i;
   logic                  carry_i;
   logic                  subtract_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  carry_o;
   logic                  overflow_o;

   modport master (
      output valid_i, operand_A_i, operand_B_i, carry_i, subtract_i, ready_i,
      input  ready_o, valid_o, result_o, carry_o, overflow_o
   );

   modport slave (
      input  valid_i, operand_A_i, operand_B_i, carry_i, subtract_i, ready_i,
      output ready_o, valid_o, result_o, carry_o, overflow_o
   );

endinterface

// File: rtl/adder_block_stage.sv
// -----------------------------------------------------------------------------
// adder_block_stage
// Combinational WIDTH-bit slice adder used once per pipeline stage.
//   a_i, b_i    : operand slices (b_i already inverted for subtract)
//   carry_i     : carry into the slice LSB
//   sum_o       : slice sum
//   carry_o     : carry out of the slice MSB
//   msb_carry_o : carry into the slice MSB (for signed overflow)
// -----------------------------------------------------------------------------
module adder_block_stage #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             msb_carry_o
);

   logic [WIDTH:0] full;

   always_comb begin
      full        = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};
      sum_o       = full[WIDTH-1:0];
      carry_o     = full[WIDTH];
      // MSB sum bit is a ^ b ^ cin, so the carry entering the MSB falls out by XOR.
      msb_carry_o = full[WIDTH-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1];
   end

endmodule

// File: rtl/pipelined_block_adder.sv
// -----------------------------------------------------------------------------
// pipelined_block_adder
// Add/subtract unit whose carry chain is cut into STAGES registered stages of
// BLOCK_WIDTH bits each; one operation per cycle, latency STAGES registers.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset; flushes every stage
//   bus   : pipelined_block_adder_if.slave
//           in : valid_i, operand_A_i, operand_B_i, carry_i, subtract_i, ready_i
//           out: ready_o, valid_o, result_o, carry_o, overflow_o
// result = A + (B ^ {sub}) + (carry_i ^ sub); carry_o on subtract = no borrow.
// Build option PIPELINED_ADDER_BUBBLE_COLLAPSE_EN: per-stage stall so empty
// stages are squeezed out while the output is blocked. Undefined: one global
// stall (valid_o && !ready_i) freezes every stage.
// -----------------------------------------------------------------------------
module pipelined_block_adder
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   pipelined_block_adder_if.slave bus
);

   localparam int STAGES = num_stages(DATA_WIDTH, BLOCK_WIDTH);
   localparam int LAST   = STAGES - 1;

   stage_t                 pipe_q [STAGES];
   stage_t                 pipe_d [STAGES];
   stage_t                 src    [STAGES];  // what each stage's slice adder reads
   logic [BLOCK_WIDTH-1:0] blk_sum [STAGES];
   logic [STAGES-1:0]      blk_cout;
   logic [STAGES-1:0]      blk_msb_cin;
   logic [STAGES-1:0]      load_en;

   // Stage 0 reads the ports (subtract folded into B' and cin0); stage k reads
   // the record left in register k-1.
   // NOTE: every always_comb output is given a full default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      src[0]       = '0;
      src[0].valid = bus.valid_i;
      src[0].a     = bus.operand_A_i;
      src[0].b     = (op_e'(bus.subtract_i) == SUB) ? ~bus.operand_B_i : bus.operand_B_i;
      src[0].carry = bus.carry_i ^ bus.subtract_i;
      for (int k = 1; k < STAGES; k++) begin
         src[k] = pipe_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_block_stage #(
         .WIDTH(BLOCK_WIDTH)
      ) u_blk (
         .a_i        (src[k].a[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .b_i        (src[k].b[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .carry_i    (src[k].carry),
         .sum_o      (blk_sum[k]),
         .carry_o    (blk_cout[k]),
         .msb_carry_o(blk_msb_cin[k])
      );
   end

   // Each stage writes its slice into the skewed result and forwards its carry.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         pipe_d[k]                                  = src[k];
         pipe_d[k].sum[k*BLOCK_WIDTH +: BLOCK_WIDTH] = blk_sum[k];
         pipe_d[k].carry                            = blk_cout[k];
         pipe_d[k].overflow                         = blk_msb_cin[k] ^ blk_cout[k];
      end
   end

`ifdef PIPELINED_ADDER_BUBBLE_COLLAPSE_EN
   // A stage may load when it is empty or when everything downstream of it
   // is moving; walking from the output backwards builds that chain.
   always_comb begin
      logic chain;
      chain   = bus.ready_i;
      load_en = '0;
      for (int k = LAST; k >= 0; k--) begin
         chain      = !pipe_q[k].valid || chain;
         load_en[k] = chain;
      end
   end
`else
   logic stall;

   always_comb begin
      stall   = pipe_q[LAST].valid && !bus.ready_i;
      load_en = {STAGES{!stall}};
   end
`endif

   // NOTE: state registers use non-blocking assignments so every stage samples
   // its predecessor's pre-edge value.
   // NOTE: reset clears the data fields as well as the valid bits, so the
   // result/carry/overflow outputs read zero after reset rather than stale sums.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load_en[k]) begin
               pipe_q[k] <= pipe_d[k];
            end
         end
      end
   end

   assign bus.ready_o    = load_en[0] && !rst_i;
   assign bus.valid_o    = pipe_q[LAST].valid;
   assign bus.result_o   = pipe_q[LAST].sum;
   assign bus.carry_o    = pipe_q[LAST].carry;
   assign bus.overflow_o = pipe_q[LAST].overflow;

endmodule

// File: tb/tb_pipelined_block_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_block_adder
// Directed bench for pipelined_block_adder (DATA_WIDTH=32, BLOCK_WIDTH=8).
// Compile with PIPELINED_ADDER_BUBBLE_COLLAPSE_EN to also check that ready_o
// stays high during a downstream stall until every stage is occupied.
// -----------------------------------------------------------------------------
module tb_pipelined_block_adder;
   import adder_pkg::*;

   localparam int DW     = 32;
   localparam int STAGES = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_asserts = 0;
   int   n_fail    = 0;

   pipelined_block_adder_if #(.DATA_WIDTH(DW)) bus ();

   pipelined_block_adder #(
      .DATA_WIDTH (DW),
      .BLOCK_WIDTH(8)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reference: {overflow, carry, result} of A + B' + cin0.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      logic [31:0] bb;
      logic [32:0] s;
      logic        c31;
      bb  = sub ? ~b : b;
      s   = {1'b0, a} + {1'b0, bb} + {32'd0, cin ^ sub};
      c31 = s[31] ^ a[31] ^ bb[31];
      return {c31 ^ s[32], s[32], s[31:0]};
   endfunction

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
      bus.valid_i     = 1'b1;
      bus.operand_A_i = a;
      bus.operand_B_i = b;
      bus.carry_i     = cin;
      bus.subtract_i  = sub;
   endtask

   task automatic idle();
      bus.valid_i     = 1'b0;
      bus.operand_A_i = $urandom;
      bus.operand_B_i = $urandom;
      bus.carry_i     = 1'($urandom);
      bus.subtract_i  = 1'($urandom);
   endtask

   // One isolated operation on an empty pipe with hand-computed expectations.
   task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub, input logic [31:0] exp_res,
                             input logic exp_c, input logic exp_v);
      int lat;
      bus.ready_i = 1'b1;
      check({tag, " ready_o before issue"}, bus.ready_o, 1'b1);
      drive_op(a, b, cin, sub);
      tick();
      idle();
      lat = 0;
      while (bus.valid_o !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, STAGES - 1);
      check({tag, " result_o"}, bus.result_o, exp_res);
      check({tag, " carry_o"}, bus.carry_o, exp_c);
      check({tag, " overflow_o"}, bus.overflow_o, exp_v);
      tick();
      check({tag, " drained"}, bus.valid_o, 1'b0);
   endtask

   logic [31:0] sa [8];
   logic [31:0] sb [8];
   logic        scin [8];
   logic        ssub [8];
   logic [33:0] exp_q [$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [33:0] exp;
      logic [33:0] prev_out;
      logic        was_stalled;
      int          issued;
      int          received;
      int          inflight;
      int          cyc;

      // ---- Reset held 3 cycles with valid_i asserted --------------------------
      rst_i       = 1'b1;
      bus.ready_i = 1'b1;
      drive_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
      repeat (3) tick();
      check("reset valid_o", bus.valid_o, 1'b0);
      check("reset result_o", bus.result_o, 32'h0);
      check("reset carry_o", bus.carry_o, 1'b0);
      check("reset overflow_o", bus.overflow_o, 1'b0);
      check("reset ready_o", bus.ready_o, 1'b0);
      rst_i = 1'b0;
      idle();
      #1;
      check("ready_o after release", bus.ready_o, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("no output after reset", bus.valid_o, 1'b0);
      end

      // ---- Directed single operations -----------------------------------------
      run_single("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_single("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_single("sub 0-0-1", 32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_single("add signed ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_single("sub cross-block borrow", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
      run_single("add carry-in", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);

      // ---- 8-op stream with one input bubble and a 3-cycle output stall -------
      for (int i = 0; i < 8; i++) begin
         sa[i]   = $urandom;
         sb[i]   = $urandom;
         scin[i] = 1'($urandom);
         ssub[i] = 1'($urandom);
      end
      issued      = 0;
      received    = 0;
      inflight    = 0;
      cyc         = 0;
      was_stalled = 1'b0;
      prev_out    = '0;
      while (received < 8 && cyc < 60) begin
         bus.ready_i = !(cyc >= 5 && cyc <= 7);
         if (issued < 8 && cyc != 2) drive_op(sa[issued], sb[issued], scin[issued], ssub[issued]);
         else idle();
         #1;
         if (was_stalled)
            check("stream outputs stable while stalled",
                  {bus.overflow_o, bus.carry_o, bus.result_o}, prev_out);
`ifdef PIPELINED_ADDER_BUBBLE_COLLAPSE_EN
         check("collapse ready_o until pipe full", bus.ready_o,
               !(inflight == STAGES && !bus.ready_i));
`endif
         if (bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
               check("stream spurious output", bus.valid_o, 1'b0);
            end else begin
               exp = exp_q.pop_front();
               check("stream result_o", bus.result_o, exp[31:0]);
               check("stream carry_o", bus.carry_o, exp[32]);
               check("stream overflow_o", bus.overflow_o, exp[33]);
               received++;
               inflight--;
            end
         end
         was_stalled = bus.valid_o && !bus.ready_i;
         prev_out    = {bus.overflow_o, bus.carry_o, bus.result_o};
         if (bus.valid_i && bus.ready_o) begin
            exp_q.push_back(model(sa[issued], sb[issued], scin[issued], ssub[issued]));
            issued++;
            inflight++;
         end
         tick();
         cyc++;
      end
      idle();
      bus.ready_i = 1'b1;
      check("stream results received", received, 8);
      check("stream ops issued", issued, 8);
      check("stream scoreboard empty", exp_q.size(), 0);
      for (int i = 0; i < 5; i++) begin
         check("stream no duplicate output", bus.valid_o, 1'b0);
         tick();
      end

      // ---- Reset with 3 operations in flight ----------------------------------
      for (int i = 0; i < 3; i++) begin
         drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
         tick();
      end
      idle();
      check("in-flight before reset", bus.valid_o, 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("flushed op never emerges", bus.valid_o, 1'b0);
      end
      run_single("after flush", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_block_adder.md
Name: pipelined_block_adder

Overview:
- Pipelined add/subtract unit that sits directly downstream of operand sourcing and feeds result consumers.
- It is the clocked, pipelined counterpart of the combinational adders: same operand/carry port names, same {carry_o, result_o} contract.
- The carry chain is cut into DATA_WIDTH/BLOCK_WIDTH registered stages, each adding one BLOCK_WIDTH slice.
- Throughput is one operation per cycle, with a valid/ready handshake on input and output.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 8, bits summed per pipeline stage; STAGES = DATA_WIDTH/BLOCK_WIDTH (default 4).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  unit accepts an operation this cycle.
- operand_A_i  in  DATA_WIDTH  first operand.
- operand_B_i  in  DATA_WIDTH  second operand.
- carry_i  in  1  carry-in (add) or borrow-in (subtract).
- subtract_i  in  1  0: A+B+carry_i; 1: A-B-carry_i.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  DATA_WIDTH  sum/difference.
- carry_o  out  1  carry out of MSB; on subtract, 1 = no borrow.
- overflow_o  out  1  signed overflow.

Behaviour:
- Effective operation: B' = operand_B_i XOR {DATA_WIDTH{subtract_i}}; cin0 = carry_i XOR subtract_i; result = A + B' + cin0, modulo 2^DATA_WIDTH.
- Stage k (0..STAGES-1) adds slice [k*BLOCK_WIDTH +: BLOCK_WIDTH] of A and B' plus the registered carry from stage k-1 (stage 0 uses cin0).
- Unconsumed upper operand slices travel with the stage; lower result slices are skewed forward.
- Each stage has its own valid bit, so bubbles propagate as invalid entries.
- overflow_o = carry into MSB XOR carry out of MSB, computed in the last stage.
- Latency: an operation accepted at edge N appears on valid_o/result_o after edge N+STAGES-1 (4 cycles of visibility delay for the default).
- Handshake:
  - Transfer in when valid_i && ready_o; transfer out when valid_o && ready_i.
  - Baseline stall rule: stall = valid_o && !ready_i. On stall every stage holds; ready_o = !stall.
  - While stalled, result_o/carry_o/overflow_o stay stable.
  - valid_i is ignored when ready_o=0; operands need not be held.
- Reset (rst_i high at an edge):
  - Clears all stage valid bits and data registers.
  - Outputs: valid_o=0, result_o=0, carry_o=0, overflow_o=0.
  - ready_o=0 while rst_i high; ready_o=1 on the first cycle after release.
  - In-flight operations are discarded, never emitted.
- Boundaries:
  - Simultaneous output transfer and input acceptance in the same cycle are legal: full throughput.
  - valid_i with an empty pipe takes the normal latency; there is no bypass.
  - STAGES=1 degenerates to a registered single-cycle adder.

Optional Feature:
- Macro PIPELINED_ADDER_BUBBLE_COLLAPSE_EN.
- Defined: per-stage stall. Stage k advances if stage k+1 is empty or advancing; ready_o = !stage0_valid || stage0_advances. Bubbles are squeezed out while the output is blocked, so up to STAGES operations are accepted during a downstream stall.
- Undefined: global stall as described above. Bubbles are preserved and input is blocked whenever the output is blocked.
- Ordering and results are identical in both modes.

Decomposition:
- Package adder_pkg:
  - STAGES computation function.
  - Typedef stage_t {valid, sum slices, carry, remaining A/B' slices}.
  - Operation enum ADD=0/SUB=1.
- Sub-module adder_block_stage: combinational BLOCK_WIDTH slice adder with outputs sum, carry_o and MSB carry-in (for overflow). Instantiated STAGES times by generate.

Test Plan (DATA_WIDTH=32, BLOCK_WIDTH=8):
- Reset held 3 cycles with valid_i=1 -> valid_o=0, result_o=0, ready_o=0; no output after release.
- Add A=0xFFFF_FFFF, B=0x0000_0001, carry_i=0 -> 4 cycles later result_o=0x0000_0000, carry_o=1, overflow_o=0.
- Sub A=5, B=7, carry_i=0 -> result_o=0xFFFF_FFFE, carry_o=0, overflow_o=0. Sub A=0, B=0, carry_i=1 -> 0xFFFF_FFFF, carry_o=0.
- Add A=0x7FFF_FFFF, B=1 -> result_o=0x8000_0000, overflow_o=1, carry_o=0.
- 8 back-to-back random ops with ready_i low for 3 cycles mid-stream -> 8 results in order, matching the A+B'+cin0 model; outputs stable during the stall; no loss or duplication. With the macro defined, also check ready_o stays high until the pipe is full.
- 3 ops in flight, rst_i pulsed 1 cycle -> none emerge; the next op issued after reset returns the correct result with 4-cycle latency.
